elevator_car_model: RTL and testbench
=====================================

Name: elevator_car_model

Overview:
- Cycle-accurate behavioural model of the car and shaft on the far side of the elevator controller's motor/sensor interface.
- Consumes the controller's motor command `ac` and `doorOpen`, and models car position and travel time between floors.
- Drives the floor-sensor lines `s1`/`s2`/`s3` back to the controller.
- Flags illegal commands (over-travel, moving with door open, bad codes) so closed-loop benches catch controller bugs.

Parameters:
- TRAVEL_CYCLES, 8: clock cycles spent between adjacent floors while moving; must be ≥2.
- GRACE_CYCLES, 2: cycles the car dwells at each floor with its sensor asserted before re-sampling `ac`; must be ≥1.
- START_FLOOR, 1: floor the car occupies after reset; legal values 1..3.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- ac  input  2  motor command: 00 stop, 10 up, 01 down, 11 illegal.
- doorOpen  input  1  door command from controller; 1 = door open.
- s1  output  1  floor-1 sensor; high while the car is in ARRIVE at floor 1.
- s2  output  1  floor-2 sensor; high while the car is in ARRIVE at floor 2.
- s3  output  1  floor-3 sensor; high while the car is in ARRIVE at floor 3.
- pos_floor  output  2  current or last-passed floor, 1..3.
- moving  output  1  high in MOVE_UP / MOVE_DOWN.
- fault  output  1  sticky error flag.
- fault_code  output  2  first fault cause: 01 ac=11, 10 over-travel, 11 door open at motion.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0, async): state=IDLE, pos_floor=START_FLOOR, travel counter=0, grace counter=0, s1/s2/s3=0, moving=0, fault=0, fault_code=00.
- After reset release, all changes occur on the rising clk edge only.

States: IDLE, MOVE_UP, MOVE_DOWN, ARRIVE, FAULT.

IDLE (stationary at pos_floor, sensors low) samples ac and doorOpen every edge:
- ac=00: stay in IDLE; doorOpen is free to toggle.
- ac=11: FAULT, code 01.
- ac≠00 with doorOpen=1: FAULT, code 11.
- ac=10 at floor 3, or ac=01 at floor 1: FAULT, code 10.
- ac=10 at floor <3: MOVE_UP, counter=0.
- ac=01 at floor >1: MOVE_DOWN, counter=0.

MOVE_UP / MOVE_DOWN:
- Counter increments each edge.
- ac is ignored while moving: the car cannot stop between floors, and a stop or reverse command takes effect at the next floor.
- doorOpen=1 on any edge: FAULT, code 11. This check has priority over arrival.
- On the edge where counter==TRAVEL_CYCLES-1: pos_floor ±1, state=ARRIVE, grace counter=0.
- Latency: ac sampled in IDLE at edge E0 gives the next sensor high after edge E0+TRAVEL_CYCLES.

ARRIVE:
- s<pos_floor>=1, exactly one sensor high, moving=0.
- Grace counter increments each edge; ac is not checked until GRACE_CYCLES have elapsed.
- On the edge where grace counter==GRACE_CYCLES-1, decide using the same rules as IDLE. Every stop therefore produces a sensor pulse GRACE_CYCLES long.
  - ac=00: go to IDLE.
  - Legal ac=10 or ac=01: resume motion directly; a pass-through floor still pulses its sensor.
  - Illegal command: FAULT with the codes above.
- doorOpen=1 during ARRIVE is legal only if ac=00 at decision.

FAULT:
- Sticky until rst=0.
- moving=0, sensors=0, pos_floor frozen.
- fault=1; fault_code holds the first cause only.

Simultaneous events:
- ac=11 together with doorOpen=1 reports code 01.
- Priority order: 01 > 11 > 10.

Invariants:
- pos_floor never leaves 1..3.
- At most one of s1/s2/s3 is high.
- moving and any s_k are never high together.

Reset mid-move: the car snaps to START_FLOOR. This is a model simplification and is accepted.

Test Plan (TRAVEL_CYCLES=8, GRACE_CYCLES=2, START_FLOOR=1):
1. Reset release, ac=00, doorOpen=0 for 20 cycles -> pos_floor=1, s1..s3=0, moving=0, fault=0 throughout.
2. ac=10 held from E0 -> moving=1 from E0+1; s2=1 after E0+8 for 2 cycles; car resumes upward; s3=1 after E0+18; then ac=00 -> IDLE, pos_floor=3, fault=0.
3. Car idle at floor 3, ac=10 -> FAULT next edge, fault_code=10, moving=0, sensors stay 0 until rst=0.
4. From floor 1, ac=10 at E0, then ac=00 at E0+3 -> car still reaches floor 2 (s2 high after E0+8), then enters IDLE with pos_floor=2.
5. While MOVE_DOWN from floor 3, doorOpen=1 for one cycle -> FAULT, fault_code=11, pos_floor=3, s2 never asserts.
6. ac=11 with doorOpen=1 in IDLE -> fault_code=01; then pulse rst=0 mid-cycle -> outputs clear immediately (async), pos_floor=1, fault=0.

Source files
------------

// File: rtl/elevator_car_model_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | elevator_car_model_if                                                 |
// | Motor/sensor link between the elevator controller and the car model.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface elevator_car_model_if;
  logic [1:0] ac;
  logic       doorOpen;
  logic       s1;
  logic       s2;
  logic       s3;
  logic [1:0] pos_floor;
  logic       moving;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output ac, doorOpen,
    input  s1, s2, s3, pos_floor, moving, fault, fault_code
  );

  modport slave (
    input  ac, doorOpen,
    output s1, s2, s3, pos_floor, moving, fault, fault_code
  );
endinterface
`default_nettype wire

// File: rtl/elevator_car_model.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | elevator_car_model                                                    |
// | Three-floor car/shaft model: travel timing, floor sensors, fault trap. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module elevator_car_model #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int GRACE_CYCLES  = 2,
  parameter int START_FLOOR   = 1
) (
  input  wire logic           clk,
  input  wire logic           rst,
  elevator_car_model_if.slave car
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    ARRIVE    = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int c_TRAV_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int c_GRACE_W = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;
  localparam logic [c_TRAV_W-1:0]  c_TRAV_LAST  = c_TRAV_W'(TRAVEL_CYCLES - 1);
  localparam logic [c_GRACE_W-1:0] c_GRACE_LAST = c_GRACE_W'(GRACE_CYCLES - 1);
  localparam logic [1:0]           c_START      = 2'(START_FLOOR);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_pos;
  logic [1:0]            w_pos_nxt;
  logic [c_TRAV_W-1:0]   r_trav;
  logic [c_TRAV_W-1:0]   w_trav_nxt;
  logic [c_GRACE_W-1:0]  r_grace;
  logic [c_GRACE_W-1:0]  w_grace_nxt;
  logic [1:0]            r_code;
  logic [1:0]            w_code_nxt;

  state_t                w_dec_state;
  logic [1:0]            w_dec_code;

  // Command decision shared by IDLE and the end of the ARRIVE dwell;
  // the if-chain order is the fault priority 01 > 11 > 10.
  always_comb begin
    w_dec_state = IDLE;
    w_dec_code  = 2'b00;
    if (car.ac == 2'b11) begin
      w_dec_state = FAULT;
      w_dec_code  = 2'b01;
    end else if (car.ac != 2'b00 && car.doorOpen) begin
      w_dec_state = FAULT;
      w_dec_code  = 2'b11;
    end else if ((car.ac == 2'b10 && r_pos == 2'd3) ||
                 (car.ac == 2'b01 && r_pos == 2'd1)) begin
      w_dec_state = FAULT;
      w_dec_code  = 2'b10;
    end else if (car.ac == 2'b10) begin
      w_dec_state = MOVE_UP;
    end else if (car.ac == 2'b01) begin
      w_dec_state = MOVE_DOWN;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_trav_nxt  = r_trav;
    w_grace_nxt = r_grace;
    w_code_nxt  = r_code;
    case (r_state)
      IDLE: begin
        w_state_nxt = w_dec_state;
        w_code_nxt  = w_dec_code;
        w_trav_nxt  = '0;
      end
      MOVE_UP, MOVE_DOWN: begin
        if (car.doorOpen) begin
          w_state_nxt = FAULT;
          w_code_nxt  = 2'b11;
        end else if (r_trav == c_TRAV_LAST) begin
          w_state_nxt = ARRIVE;
          w_grace_nxt = '0;
          w_pos_nxt   = (r_state == MOVE_UP) ? r_pos + 2'd1 : r_pos - 2'd1;
        end else begin
          w_trav_nxt = r_trav + 1'b1;
        end
      end
      ARRIVE: begin
        if (r_grace == c_GRACE_LAST) begin
          w_state_nxt = w_dec_state;
          w_code_nxt  = w_dec_code;
          w_trav_nxt  = '0;
        end else begin
          w_grace_nxt = r_grace + 1'b1;
        end
      end
      default: begin
        w_state_nxt = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pos   <= c_START;
      r_trav  <= '0;
      r_grace <= '0;
      r_code  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_trav  <= w_trav_nxt;
      r_grace <= w_grace_nxt;
      r_code  <= w_code_nxt;
    end
  end

  assign car.s1         = (r_state == ARRIVE) && (r_pos == 2'd1);
  assign car.s2         = (r_state == ARRIVE) && (r_pos == 2'd2);
  assign car.s3         = (r_state == ARRIVE) && (r_pos == 2'd3);
  assign car.pos_floor  = r_pos;
  assign car.moving     = (r_state == MOVE_UP) || (r_state == MOVE_DOWN);
  assign car.fault      = (r_state == FAULT);
  assign car.fault_code = r_code;

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_model.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_elevator_car_model                                                 |
// | Cycle-stamped scoreboard bench for the elevator car model.            |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_elevator_car_model;

  typedef struct {
    int         at_cyc;
    string      name;
    logic [8:0] vals;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t sb_q[$];

  elevator_car_model_if bus ();

  elevator_car_model #(
    .TRAVEL_CYCLES(8),
    .GRACE_CYCLES (2),
    .START_FLOOR  (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .car(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  // Packing: {s1,s2,s3, pos_floor, moving, fault, fault_code}
  function automatic logic [8:0] mk(input logic [2:0] s, input logic [1:0] pos,
                                    input logic mv, input logic flt,
                                    input logic [1:0] code);
    return {s, pos, mv, flt, code};
  endfunction

  task automatic expect_at(input int at, input string name, input logic [8:0] v);
    exp_t e;
    e.at_cyc = at;
    e.name   = name;
    e.vals   = v;
    sb_q.push_back(e);
  endtask

  task automatic wait_n(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.ac = 2'b00;
    bus.doorOpen = 1'b0;
    expect_at(cyc, "reset_state", mk(3'b000, 2'd1, 1'b0, 1'b0, 2'b00));
    wait_n(2);
    rst = 1'b1;
  endtask

  // Monitor: compare every expectation whose cycle stamp is due.
  initial begin
    logic [8:0] act;
    forever begin
      @(negedge clk);
      #1;
      act = {bus.s1, bus.s2, bus.s3, bus.pos_floor, bus.moving, bus.fault, bus.fault_code};
      n_tests++;
      if ((32'(bus.s1) + 32'(bus.s2) + 32'(bus.s3)) > 1 ||
          (bus.moving && (bus.s1 || bus.s2 || bus.s3)) ||
          bus.pos_floor == 2'd0) begin
        n_fail++;
        $display("FAIL invariant cyc=%0d got=%b", cyc, act);
      end
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].at_cyc == cyc) begin
          n_tests++;
          if (act !== sb_q[i].vals) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", sb_q[i].name, cyc, act, sb_q[i].vals);
          end
          sb_q.delete(i);
        end else if (sb_q[i].at_cyc < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s missed at cyc=%0d", sb_q[i].name, sb_q[i].at_cyc);
          sb_q.delete(i);
        end
      end
    end
  end

  initial begin
    int c;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.ac = 2'b00;
    bus.doorOpen = 1'b0;

    // 1: reset then 20 idle cycles at floor 1
    wait_n(2);
    expect_at(cyc, "reset_state", mk(3'b000, 2'd1, 1'b0, 1'b0, 2'b00));
    wait_n(1);
    rst = 1'b1;
    c = cyc;
    for (int i = 1; i <= 20; i++) expect_at(c + i, "idle_f1", mk(3'b000, 2'd1, 1'b0, 1'b0, 2'b00));
    wait_n(21);

    // 2: ac=10 held: pass floor 2, stop at floor 3
    c = cyc;
    bus.ac = 2'b10;
    expect_at(c + 1,  "up_moving",   mk(3'b000, 2'd1, 1'b1, 1'b0, 2'b00));
    expect_at(c + 8,  "up_last_trv", mk(3'b000, 2'd1, 1'b1, 1'b0, 2'b00));
    expect_at(c + 9,  "s2_pulse0",   mk(3'b010, 2'd2, 1'b0, 1'b0, 2'b00));
    expect_at(c + 10, "s2_pulse1",   mk(3'b010, 2'd2, 1'b0, 1'b0, 2'b00));
    expect_at(c + 11, "resume_up",   mk(3'b000, 2'd2, 1'b1, 1'b0, 2'b00));
    expect_at(c + 18, "up2_moving",  mk(3'b000, 2'd2, 1'b1, 1'b0, 2'b00));
    expect_at(c + 19, "s3_pulse0",   mk(3'b001, 2'd3, 1'b0, 1'b0, 2'b00));
    expect_at(c + 20, "s3_pulse1",   mk(3'b001, 2'd3, 1'b0, 1'b0, 2'b00));
    expect_at(c + 21, "idle_f3",     mk(3'b000, 2'd3, 1'b0, 1'b0, 2'b00));
    expect_at(c + 26, "idle_f3_hold",mk(3'b000, 2'd3, 1'b0, 1'b0, 2'b00));
    wait_n(13);
    bus.ac = 2'b00;
    wait_n(14);

    // 3: up at floor 3 is over-travel
    c = cyc;
    bus.ac = 2'b10;
    expect_at(c + 1, "overtravel_up",  mk(3'b000, 2'd3, 1'b0, 1'b1, 2'b10));
    expect_at(c + 6, "fault_sticky",   mk(3'b000, 2'd3, 1'b0, 1'b1, 2'b10));
    wait_n(4);
    bus.ac = 2'b00;
    expect_at(cyc + 3, "fault_sticky_ac0", mk(3'b000, 2'd3, 1'b0, 1'b1, 2'b10));
    wait_n(4);
    do_reset();

    // 4: stop request while moving takes effect at floor 2
    @(negedge clk);
    c = cyc;
    bus.ac = 2'b10;
    expect_at(c + 2,  "t4_moving", mk(3'b000, 2'd1, 1'b1, 1'b0, 2'b00));
    expect_at(c + 9,  "t4_s2_0",   mk(3'b010, 2'd2, 1'b0, 1'b0, 2'b00));
    expect_at(c + 10, "t4_s2_1",   mk(3'b010, 2'd2, 1'b0, 1'b0, 2'b00));
    expect_at(c + 11, "t4_idle_f2",mk(3'b000, 2'd2, 1'b0, 1'b0, 2'b00));
    expect_at(c + 13, "t4_idle_f2b",mk(3'b000, 2'd2, 1'b0, 1'b0, 2'b00));
    wait_n(3);
    bus.ac = 2'b00;
    wait_n(11);

    // 5: climb to floor 3, then door opens while moving down
    c = cyc;
    bus.ac = 2'b10;
    expect_at(c + 9,  "t5_s3", mk(3'b001, 2'd3, 1'b0, 1'b0, 2'b00));
    expect_at(c + 11, "t5_idle_f3", mk(3'b000, 2'd3, 1'b0, 1'b0, 2'b00));
    wait_n(3);
    bus.ac = 2'b00;
    wait_n(9);
    c = cyc;
    bus.ac = 2'b01;
    expect_at(c + 1,  "dn_moving",   mk(3'b000, 2'd3, 1'b1, 1'b0, 2'b00));
    expect_at(c + 3,  "dn_moving2",  mk(3'b000, 2'd3, 1'b1, 1'b0, 2'b00));
    expect_at(c + 4,  "door_fault",  mk(3'b000, 2'd3, 1'b0, 1'b1, 2'b11));
    expect_at(c + 9,  "no_s2",       mk(3'b000, 2'd3, 1'b0, 1'b1, 2'b11));
    expect_at(c + 12, "door_sticky", mk(3'b000, 2'd3, 1'b0, 1'b1, 2'b11));
    wait_n(3);
    bus.doorOpen = 1'b1;
    wait_n(1);
    bus.doorOpen = 1'b0;
    bus.ac = 2'b00;
    wait_n(9);
    do_reset();

    // Down at floor 1 is over-travel
    @(negedge clk);
    c = cyc;
    bus.ac = 2'b01;
    expect_at(c + 1, "overtravel_dn", mk(3'b000, 2'd1, 1'b0, 1'b1, 2'b10));
    wait_n(3);
    do_reset();

    // Motion request with door open in IDLE
    @(negedge clk);
    c = cyc;
    bus.ac = 2'b10;
    bus.doorOpen = 1'b1;
    expect_at(c + 1, "door_idle_up", mk(3'b000, 2'd1, 1'b0, 1'b1, 2'b11));
    wait_n(3);
    do_reset();

    // 6: ac=11 with door open -> code 01, then async mid-cycle reset
    @(negedge clk);
    c = cyc;
    bus.ac = 2'b11;
    bus.doorOpen = 1'b1;
    expect_at(c + 1, "illegal_ac", mk(3'b000, 2'd1, 1'b0, 1'b1, 2'b01));
    expect_at(c + 3, "illegal_ac_hold", mk(3'b000, 2'd1, 1'b0, 1'b1, 2'b01));
    wait_n(4);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.ac = 2'b00;
    bus.doorOpen = 1'b0;
    expect_at(cyc, "async_reset", mk(3'b000, 2'd1, 1'b0, 1'b0, 2'b00));
    wait_n(2);
    rst = 1'b1;
    expect_at(cyc + 2, "post_reset_idle", mk(3'b000, 2'd1, 1'b0, 1'b0, 2'b00));
    wait_n(4);

    foreach (sb_q[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s never checked (due cyc=%0d)", sb_q[i].name, sb_q[i].at_cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
